// File: rtl/bit_rotate_pick_unit.sv
// Registered rotate-right / rotate-left / popcount / oldest-first pick on one
// request vector, rotation amount given as a one-hot pointer.
module bit_rotate_pick_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_in,
    input  logic [WIDTH-1:0]           i_sel_oh,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_rshift,
    output logic [WIDTH-1:0]           o_lshift,
    output logic [$clog2(WIDTH):0]     o_cnt,
    output logic [WIDTH-1:0]           o_pick_oh
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = IW + 1;

    logic [WIDTH-1:0] w_rshift;
    logic [WIDTH-1:0] w_lshift;
    logic [WIDTH-1:0] w_lsb;
    logic [WIDTH-1:0] w_pick;
    logic [CW-1:0]    w_cnt;

    // Mux-OR rotators: every set pointer bit contributes its rotation, so a
    // zero pointer yields zero and a multi-hot pointer ORs the rotations.
    always_comb begin
        w_rshift = '0;
        w_lshift = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_sel_oh[k]) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_rshift[IW'(i)] = w_rshift[IW'(i)] | i_in[IW'((i + k) % WIDTH)];
                    w_lshift[IW'((i + k) % WIDTH)] = w_lshift[IW'((i + k) % WIDTH)] | i_in[IW'(i)];
                end
            end
        end
    end

    // Pick: isolate the lowest set bit in pointer-relative order, then rotate
    // it back to absolute position with the same pointer.
    always_comb begin
        w_lsb  = w_rshift & (~w_rshift + WIDTH'(1));
        w_pick = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_sel_oh[k]) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_pick[IW'((i + k) % WIDTH)] = w_pick[IW'((i + k) % WIDTH)] | w_lsb[IW'(i)];
                end
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + {{(CW-1){1'b0}}, i_in[IW'(i)]};
        end
    end

    logic                r_valid;
    logic [WIDTH-1:0]    r_rshift;
    logic [WIDTH-1:0]    r_lshift;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_pick_oh;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_rshift  <= '0;
            r_lshift  <= '0;
            r_cnt     <= '0;
            r_pick_oh <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_rshift  <= w_rshift;
                r_lshift  <= w_lshift;
                r_cnt     <= w_cnt;
                r_pick_oh <= w_pick;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_rshift  = r_rshift;
    assign o_lshift  = r_lshift;
    assign o_cnt     = r_cnt;
    assign o_pick_oh = r_pick_oh;

endmodule

// File: tb/tb_bit_rotate_pick_unit.sv
// Self-checking bench for bit_rotate_pick_unit at WIDTH=8: directed vectors,
// hold, asynchronous reset and randomized traffic against a behavioural model.
module tb_bit_rotate_pick_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] din;
    logic [W-1:0] sel;
    logic         o_valid;
    logic [W-1:0] o_rshift;
    logic [W-1:0] o_lshift;
    logic [3:0]   o_cnt;
    logic [W-1:0] o_pick;

    int n_tests;
    int n_fail;

    bit_rotate_pick_unit #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_valid   (valid),
        .i_in      (din),
        .i_sel_oh  (sel),
        .o_valid   (o_valid),
        .o_rshift  (o_rshift),
        .o_lshift  (o_lshift),
        .o_cnt     (o_cnt),
        .o_pick_oh (o_pick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rot_r(input logic [W-1:0] v, input int k);
        logic [2*W-1:0] d;
        d = {v, v} >> k;
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] rot_l(input logic [W-1:0] v, input int k);
        logic [2*W-1:0] d;
        d = {v, v} << k;
        return d[2*W-1:W];
    endfunction

    // Model straight from the rules: OR of rotations, lowest-bit isolate, popcount.
    task automatic model(input logic [W-1:0] v, input logic [W-1:0] s,
                         output logic [W-1:0] r, output logic [W-1:0] l,
                         output logic [3:0] c, output logic [W-1:0] p);
        logic [W-1:0] lsb;
        r = '0; l = '0; p = '0; lsb = '0; c = '0;
        for (int k = 0; k < W; k++)
            if (s[k]) begin
                r |= rot_r(v, k);
                l |= rot_l(v, k);
            end
        for (int i = W - 1; i >= 0; i--)
            if (r[i]) lsb = W'(1) << i;
        for (int k = 0; k < W; k++)
            if (s[k]) p |= rot_l(lsb, k);
        for (int i = 0; i < W; i++)
            c += 4'(v[i]);
    endtask

    // Oldest-first scan from pointer k with wrap-around (one-hot pointer only).
    function automatic logic [W-1:0] scan_pick(input logic [W-1:0] v, input int k);
        for (int j = 0; j < W; j++)
            if (v[(k + j) % W]) return W'(1) << ((k + j) % W);
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; din = '0; sel = '0;
        repeat (2) step();
        n_tests++;
        if ({o_valid, o_rshift, o_lshift, o_cnt, o_pick} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%h l=%h c=%0d p=%h, want all 0",
                     o_valid, o_rshift, o_lshift, o_cnt, o_pick);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] t_in  [5] = '{8'h06, 8'h03, 8'hFF, 8'h00, 8'h5A};
        logic [W-1:0] t_sel [5] = '{8'h04, 8'h80, 8'h01, 8'h01, 8'h00};
        logic [W-1:0] t_r   [5] = '{8'h81, 8'h06, 8'hFF, 8'h00, 8'h00};
        logic [W-1:0] t_l   [5] = '{8'h18, 8'h81, 8'hFF, 8'h00, 8'h00};
        logic [3:0]   t_c   [5] = '{4'd2,  4'd2,  4'd8,  4'd0,  4'd4};
        logic [W-1:0] t_p   [5] = '{8'h04, 8'h01, 8'h01, 8'h00, 8'h00};
        for (int t = 0; t < 5; t++) begin
            valid = 1'b1; din = t_in[t]; sel = t_sel[t];
            step();
            n_tests++;
            if (o_valid !== 1'b1 || o_rshift !== t_r[t] || o_lshift !== t_l[t] ||
                o_cnt !== t_c[t] || o_pick !== t_p[t]) begin
                n_fail++;
                $display("FAIL directed_%0d: got v=%b r=%h l=%h c=%0d p=%h, want v=1 r=%h l=%h c=%0d p=%h",
                         t, o_valid, o_rshift, o_lshift, o_cnt, o_pick, t_r[t], t_l[t], t_c[t], t_p[t]);
            end
        end
    endtask

    task automatic test_hold_and_async_reset();
        valid = 1'b1; din = 8'h06; sel = 8'h04;
        step();
        valid = 1'b0; din = 8'hA5; sel = 8'h10;
        for (int c = 0; c < 2; c++) begin
            step();
            n_tests++;
            if (o_valid !== 1'b0 || o_rshift !== 8'h81 || o_lshift !== 8'h18 ||
                o_cnt !== 4'd2 || o_pick !== 8'h04) begin
                n_fail++;
                $display("FAIL hold_%0d: got v=%b r=%h l=%h c=%0d p=%h, want v=0 r=81 l=18 c=2 p=04",
                         c, o_valid, o_rshift, o_lshift, o_cnt, o_pick);
            end
        end
        valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_valid, o_rshift, o_lshift, o_cnt, o_pick} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b r=%h l=%h c=%0d p=%h, want all 0",
                     o_valid, o_rshift, o_lshift, o_cnt, o_pick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        step();
        n_tests++;
        if (o_valid !== 1'b0 || o_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b c=%0d, want v=0 c=0", o_valid, o_cnt);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] er, el, ep, xr, xl, xp;
        logic [3:0]   ec, xc;
        logic         ev;
        int           k, bad;
        er = '0; el = '0; ec = '0; ep = '0; ev = 1'b0; bad = 0;
        // Synchronise expected hold state with the last capture.
        valid = 1'b1; din = '0; sel = 8'h01;
        step();
        for (int n = 0; n < 1000; n++) begin
            k     = $urandom_range(W - 1);
            valid = ($urandom_range(3) != 0);
            din   = W'($urandom);
            if ($urandom_range(7) == 0) din = ($urandom_range(1) != 0) ? 8'hFF : 8'h00;
            sel   = W'(1) << k;
            if ($urandom_range(15) == 0) sel = W'($urandom);
            model(din, sel, xr, xl, xc, xp);
            ev = valid;
            if (valid) begin
                er = xr; el = xl; ec = xc; ep = xp;
                if (sel == (W'(1) << k)) begin
                    n_tests++;
                    if (rot_l(xr, k) !== din || xp !== scan_pick(din, k) || xc !== 4'($countones(din))) begin
                        n_fail++;
                        $display("FAIL model_selfcheck_%0d: in=%h k=%0d", n, din, k);
                    end
                end
            end
            step();
            n_tests++;
            if (o_valid !== ev || o_rshift !== er || o_lshift !== el || o_cnt !== ec || o_pick !== ep) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: in=%h sel=%h got v=%b r=%h l=%h c=%0d p=%h, want v=%b r=%h l=%h c=%0d p=%h",
                             n, din, sel, o_valid, o_rshift, o_lshift, o_cnt, o_pick, ev, er, el, ec, ep);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_hold_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
